// File: rtl/dcache_if.sv
// Bus bundles around the data cache: CPU-side byte port and memory-side block port.
// On the CPU bus the cache is the slave; on the memory bus it is the master.
interface dcache_cpu_if;
    logic       READ;
    logic       WRITE;
    logic [7:0] ADDRESS;
    logic [7:0] WRITEDATA;
    logic [7:0] READDATA;
    logic       BUSYWAIT;

    modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
    modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                    input MEM_READDATA, MEM_BUSYWAIT);
    modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                    output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back data cache, 8 blocks of 4 bytes, byte CPU port, 32-bit block memory port.
//   state     | meaning
//   IDLE      | serve hits; on a miss pick WRITEBACK (dirty victim) or FETCH
//   WRITEBACK | push victim block to memory until MEM_BUSYWAIT samples low
//   FETCH     | request new block until MEM_BUSYWAIT samples low, capture its data
//   UPDATE    | install captured block, tag, valid=1, dirty=0
module dcache (
    input  logic         CLK,
    input  logic         RESET,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q [8];
    logic [2:0]  tag_q  [8];
    logic [7:0]  valid_q;
    logic [7:0]  dirty_q;
    logic [31:0] fill_q, fill_d;

    logic [2:0]  tag;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic        req;
    logic        hit;
    logic        wr_hit;

    assign tag    = cpu.ADDRESS[7:5];
    assign idx    = cpu.ADDRESS[4:2];
    assign off    = cpu.ADDRESS[1:0];
    assign req    = cpu.READ | cpu.WRITE;
    assign hit    = valid_q[idx] && (tag_q[idx] == tag);
    assign wr_hit = (state_q == IDLE) && cpu.WRITE && hit;

    assign cpu.BUSYWAIT = RESET && req && !((state_q == IDLE) && hit);
    assign cpu.READDATA = (RESET && req) ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;

    always_comb begin
        state_d           = state_q;
        fill_d            = fill_q;
        mem.MEM_READ      = 1'b0;
        mem.MEM_WRITE     = 1'b0;
        mem.MEM_ADDRESS   = 6'h00;
        mem.MEM_WRITEDATA = 32'h0;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    state_d = dirty_q[idx] ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                mem.MEM_WRITE     = 1'b1;
                mem.MEM_ADDRESS   = {tag_q[idx], idx};
                mem.MEM_WRITEDATA = data_q[idx];
                if (!mem.MEM_BUSYWAIT) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem.MEM_READ    = 1'b1;
                mem.MEM_ADDRESS = {tag, idx};
                // memory may stop driving its data after this edge, so hold it locally
                if (!mem.MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                    fill_d  = mem.MEM_READDATA;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (wr_hit) begin
                data_q[idx][{off, 3'b000} +: 8] <= cpu.WRITEDATA;
                dirty_q[idx]                    <= 1'b1;
            end
            if (state_q == UPDATE) begin
                data_q[idx]  <= fill_q;
                tag_q[idx]   <= tag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache: block memory model with programmable busy time,
// flat byte reference model for load data, and a queue of expected memory requests.
module tb_dcache;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    dcache_cpu_if cpu ();
    dcache_mem_if mem ();

    dcache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .cpu   (cpu),
        .mem   (mem)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } mem_exp_t;

    mem_exp_t    mem_q [$];
    logic [7:0]  rd_q  [$];
    logic [31:0] mem_arr [64];
    logic [7:0]  model_mem [256];
    bit          mem_ready = 1'b0;
    int          mem_k     = 5;
    int          busy_cnt  = 0;

    function automatic logic [31:0] init_word(int w);
        logic [31:0] v;
        if (w == 9) return 32'hDDCCBBAA;
        for (int b = 0; b < 4; b++) v[b*8 +: 8] = 8'(4*w + b) ^ 8'h3C;
        return v;
    endfunction

    // Memory: a request is answered on its mem_k-th cycle; data only valid in that cycle.
    assign mem.MEM_BUSYWAIT = (mem.MEM_READ | mem.MEM_WRITE) ? (busy_cnt < mem_k - 1) : 1'b0;
    assign mem.MEM_READDATA = (mem.MEM_READ && !mem.MEM_BUSYWAIT) ? mem_arr[mem.MEM_ADDRESS]
                                                                  : 32'hDEADBEEF;

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (RESET && mem.MEM_WRITE && !mem.MEM_BUSYWAIT) begin
            mem_arr[mem.MEM_ADDRESS] <= mem.MEM_WRITEDATA;
        end
        if ((mem.MEM_READ | mem.MEM_WRITE) && mem.MEM_BUSYWAIT) busy_cnt <= busy_cnt + 1;
        else                                                     busy_cnt <= 0;
    end

    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;
    always @(negedge CLK) begin
        mem_exp_t e;
        if ((mem.MEM_READ === 1'b1 && !prev_rd) || (mem.MEM_WRITE === 1'b1 && !prev_wr)) begin
            checks++;
            if (mem.MEM_READ && mem.MEM_WRITE) begin
                errors++;
                $display("FAIL mem_exclusive: MEM_READ=%b MEM_WRITE=%b, want never both", mem.MEM_READ, mem.MEM_WRITE);
            end else if (mem_q.size() == 0) begin
                errors++;
                $display("FAIL mem_unexpected: got request wr=%b addr=%h, want none", mem.MEM_WRITE, mem.MEM_ADDRESS);
            end else begin
                e = mem_q.pop_front();
                if (mem.MEM_WRITE !== e.wr || mem.MEM_ADDRESS !== e.addr ||
                    (e.wr && mem.MEM_WRITEDATA !== e.data)) begin
                    errors++;
                    $display("FAIL mem_request: got wr=%b addr=%h data=%h, want wr=%b addr=%h data=%h",
                             mem.MEM_WRITE, mem.MEM_ADDRESS, mem.MEM_WRITEDATA, e.wr, e.addr, e.data);
                end
            end
        end
        prev_rd = (mem.MEM_READ === 1'b1);
        prev_wr = (mem.MEM_WRITE === 1'b1);
    end

    // Called just after a rising edge; returns stall count (-1 on timeout) and load data.
    task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          output int stall, output logic [7:0] rd);
        bit done = 1'b0;
        cpu.READ      = !wr;
        cpu.WRITE     = wr;
        cpu.ADDRESS   = a;
        cpu.WRITEDATA = d;
        stall = 0;
        rd    = 8'h00;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (cpu.BUSYWAIT === 1'b0) begin
                rd   = cpu.READDATA;
                done = 1'b1;
                break;
            end
            stall++;
        end
        if (!done) stall = -1;
        @(posedge CLK);
        #1;
        cpu.READ  = 1'b0;
        cpu.WRITE = 1'b0;
    endtask

    task automatic sync_model_from_mem();
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = mem_arr[i];
            for (int b = 0; b < 4; b++) model_mem[i*4 + b] = w[b*8 +: 8];
        end
    endtask

    task automatic test_reset();
        RESET       = 1'b0;
        cpu.READ    = 1'b1;
        cpu.WRITE   = 1'b0;
        cpu.ADDRESS = 8'h25;
        @(negedge CLK);
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || cpu.READDATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_cpu_outputs: got BUSYWAIT=%b READDATA=%h, want 0 and 00", cpu.BUSYWAIT, cpu.READDATA);
        end
        @(negedge CLK);
        checks++;
        if (mem.MEM_READ !== 1'b0 || mem.MEM_WRITE !== 1'b0 ||
            mem.MEM_ADDRESS !== 6'h00 || mem.MEM_WRITEDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_outputs: got rd=%b wr=%b addr=%h data=%h, want all 0",
                     mem.MEM_READ, mem.MEM_WRITE, mem.MEM_ADDRESS, mem.MEM_WRITEDATA);
        end
        @(posedge CLK);
        #1;
        RESET    = 1'b1;
        cpu.READ = 1'b0;
    endtask

    task automatic test_cold_read();
        int stall; logic [7:0] rd;
        mem_k = 5;
        mem_q.push_back('{1'b0, 6'h09, 32'h0});
        rd_q.push_back(8'hBB);
        cpu_op(1'b0, 8'h25, 8'h00, stall, rd);
        checks++;
        if (stall !== 7) begin errors++; $display("FAIL cold_read_stall: got %0d, want 7", stall); end
        checks++;
        if (rd !== rd_q[0]) begin errors++; $display("FAIL cold_read_data: got %h, want %h", rd, rd_q[0]); end
        void'(rd_q.pop_front());
    endtask

    task automatic test_read_hit();
        int stall; logic [7:0] rd;
        rd_q.push_back(8'hDD);
        cpu_op(1'b0, 8'h27, 8'h00, stall, rd);
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL read_hit_stall: got %0d, want 0", stall); end
        checks++;
        if (rd !== rd_q[0]) begin errors++; $display("FAIL read_hit_data: got %h, want %h", rd, rd_q[0]); end
        void'(rd_q.pop_front());
    endtask

    task automatic test_write_dirty_evict();
        int stall; logic [7:0] rd;
        cpu_op(1'b1, 8'h24, 8'h5A, stall, rd);
        model_mem[8'h24] = 8'h5A;
        checks++;
        if (stall !== 0) begin errors++; $display("FAIL write_hit_stall: got %0d, want 0", stall); end
        mem_k = 5;
        mem_q.push_back('{1'b1, 6'h09, 32'hDDCCBB5A});
        mem_q.push_back('{1'b0, 6'h29, 32'h0});
        rd_q.push_back(model_mem[8'hA4]);
        cpu_op(1'b0, 8'hA4, 8'h00, stall, rd);
        checks++;
        if (stall !== 12) begin errors++; $display("FAIL dirty_miss_stall: got %0d, want 12", stall); end
        checks++;
        if (rd !== rd_q[0]) begin errors++; $display("FAIL dirty_miss_data: got %h, want %h", rd, rd_q[0]); end
        void'(rd_q.pop_front());
    endtask

    task automatic test_write_miss_clean();
        int stall; logic [7:0] rd;
        mem_k = 2;
        mem_q.push_back('{1'b0, 6'h04, 32'h0});
        cpu_op(1'b1, 8'h10, 8'h77, stall, rd);
        model_mem[8'h10] = 8'h77;
        checks++;
        if (stall !== 4) begin errors++; $display("FAIL write_miss_stall: got %0d, want 4", stall); end
        rd_q.push_back(8'h77);
        cpu_op(1'b0, 8'h10, 8'h00, stall, rd);
        checks++;
        if (stall !== 0 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL write_miss_readback: got stall=%0d data=%h, want 0 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
        // evicting the block proves it was left dirty
        mem_q.push_back('{1'b1, 6'h04, {model_mem[8'h13], model_mem[8'h12], model_mem[8'h11], 8'h77}});
        mem_q.push_back('{1'b0, 6'h0C, 32'h0});
        rd_q.push_back(model_mem[8'h30]);
        cpu_op(1'b0, 8'h30, 8'h00, stall, rd);
        checks++;
        if (stall !== 6 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL dirty_after_write_miss: got stall=%0d data=%h, want 6 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    task automatic test_zero_wait();
        int stall; logic [7:0] rd;
        mem_k = 1;
        mem_q.push_back('{1'b0, 6'h12, 32'h0});
        rd_q.push_back(model_mem[8'h4B]);
        cpu_op(1'b0, 8'h4B, 8'h00, stall, rd);
        checks++;
        if (stall !== 3 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL zero_wait_miss: got stall=%0d data=%h, want 3 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
        rd_q.push_back(model_mem[8'h48]);
        cpu_op(1'b0, 8'h48, 8'h00, stall, rd);
        checks++;
        if (stall !== 0 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL back_to_back_hit: got stall=%0d data=%h, want 0 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    task automatic test_reset_fetch();
        int stall; logic [7:0] rd;
        mem_k = 5;
        mem_q.push_back('{1'b0, 6'h1B, 32'h0});
        cpu.READ    = 1'b1;
        cpu.WRITE   = 1'b0;
        cpu.ADDRESS = 8'h6C;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (cpu.BUSYWAIT !== 1'b0 || cpu.READDATA !== 8'h00) begin
            errors++;
            $display("FAIL reset_in_fetch_cpu: got BUSYWAIT=%b READDATA=%h, want 0 and 00", cpu.BUSYWAIT, cpu.READDATA);
        end
        @(posedge CLK); #1;
        RESET    = 1'b1;
        cpu.READ = 1'b0;
        @(negedge CLK);
        checks++;
        if (mem.MEM_READ !== 1'b0 || cpu.BUSYWAIT !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_fetch_abort: got MEM_READ=%b BUSYWAIT=%b, want 0 and 0", mem.MEM_READ, cpu.BUSYWAIT);
        end
        @(posedge CLK); #1;
        sync_model_from_mem();
        mem_q.push_back('{1'b0, 6'h1B, 32'h0});
        rd_q.push_back(model_mem[8'h6C]);
        cpu_op(1'b0, 8'h6C, 8'h00, stall, rd);
        checks++;
        if (stall !== 7 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL remiss_after_reset: got stall=%0d data=%h, want 7 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
        mem_q.push_back('{1'b0, 6'h09, 32'h0});
        rd_q.push_back(8'h5A);
        cpu_op(1'b0, 8'h24, 8'h00, stall, rd);
        checks++;
        if (stall !== 7 || rd !== rd_q[0]) begin
            errors++;
            $display("FAIL written_back_data: got stall=%0d data=%h, want 7 and %h", stall, rd, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 64; i++) begin
            w = init_word(i);
            for (int b = 0; b < 4; b++) model_mem[i*4 + b] = w[b*8 +: 8];
        end
        cpu.READ      = 1'b0;
        cpu.WRITE     = 1'b0;
        cpu.ADDRESS   = 8'h00;
        cpu.WRITEDATA = 8'h00;

        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_dirty_evict();
        test_write_miss_clean();
        test_zero_wait();
        test_reset_fetch();

        repeat (2) @(posedge CLK);
        checks++;
        if (mem_q.size() != 0) begin
            errors++;
            $display("FAIL mem_requests_missing: got %0d outstanding, want 0", mem_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
